// File: rtl/vmem_sequencer.sv
// Vector load/store sequencer: moves one 128-bit vector register to or from
// memory as four 32-bit beats. Optional build macro: VMEM_ALIGN_CHECK_EN.
module vmem_sequencer #(
  parameter int ADDR_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [127:0]      vstore_data,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              stall,
  output logic [127:0]      vload_data,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for start; accepts a new op
  // XFER  | one memory beat per cycle, beats 0..3
  // LAST  | loads only: collect the final read word
  // DONE  | one-cycle completion (and error) pulse
  typedef enum logic [1:0] {IDLE, XFER, LAST, DONE} state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  state_t      state;
  logic [1:0]  beat;
  logic        op_store;
  logic [31:0] words [4];

`ifndef VMEM_ALIGN_CHECK_EN
  // Low address bits are dropped in this build.
  logic unused_low_addr;
  assign unused_low_addr = ^base_addr[1:0];
`endif

  always_comb begin
    stall = 1'b0;
    if ((state == IDLE && start) || state == XFER || state == LAST)
      stall = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= 2'd0;
      op_store   <= 1'b0;
      for (int i = 0; i < 4; i++) words[i] <= 32'h0;
      vload_data <= 128'h0;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
`ifdef VMEM_ALIGN_CHECK_EN
            if (base_addr[1:0] != 2'b00) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else
`endif
            begin
              op_store  <= is_store;
              beat      <= 2'd0;
              words[0]  <= vstore_data[127:96];
              words[1]  <= vstore_data[95:64];
              words[2]  <= vstore_data[63:32];
              words[3]  <= vstore_data[31:0];
              mem_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
              mem_we    <= is_store;
              mem_wdata <= is_store ? vstore_data[127:96] : 32'h0;
              state     <= XFER;
            end
          end
        end

        XFER: begin
          // Read data lags its address by one cycle, so beat n lands word n-1.
          if (!op_store && beat != 2'd0)
            words[beat - 2'd1] <= mem_rdata;
          if (beat == LAST_BEAT) begin
            beat      <= 2'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            if (op_store) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LAST;
            end
          end else begin
            beat      <= beat + 2'd1;
            mem_addr  <= mem_addr + WORD_STEP;
            mem_wdata <= op_store ? words[beat + 2'd1] : 32'h0;
          end
        end

        LAST: begin
          vload_data <= {words[0], words[1], words[2], mem_rdata};
          done       <= 1'b1;
          state      <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
// Directed bench for vmem_sequencer: stores, loads, address wrap, reset
// mid-transfer, back-to-back ops and low-address-bit handling.
module tb_vmem_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic         is_store;
  logic [31:0]  base_addr;
  logic [127:0] vstore_data;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_we;
  logic         stall;
  logic [127:0] vload_data;
  logic         done;
  logic         err;

  int tests_run;
  int tests_failed;

  vmem_sequencer #(.ADDR_W(32), .BEATS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .base_addr(base_addr), .vstore_data(vstore_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .stall(stall), .vload_data(vload_data), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h200: return 32'hA0A1A2A3;
      32'h204: return 32'hB0B1B2B3;
      32'h208: return 32'hC0C1C2C3;
      32'h20C: return 32'hD0D1D2D3;
      default: return 32'h0;
    endcase
  endfunction

  // Read data valid one cycle after its address.
  always @(posedge clk) mem_rdata <= mem_model(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0]  st_words [4];
  logic [127:0] ld_exp;
  int           n_writes;
  int           n_done;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    st_words[0] = 32'h00112233;
    st_words[1] = 32'h44556677;
    st_words[2] = 32'h8899AABB;
    st_words[3] = 32'hCCDDEEFF;
    ld_exp = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

    rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = 32'h0; vstore_data = 128'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_vload", vload_data, 0);
    check("rst_stall", stall, 0);

    // vstr base 0x100
    tick();
    start = 1'b1; is_store = 1'b1; base_addr = 32'h100;
    vstore_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    #1;
    check("st_c0_stall", stall, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_we", mem_we, 1);
      check("st_addr", mem_addr, 32'h100 + 32'(4 * i));
      check("st_wdata", mem_wdata, st_words[i]);
      check("st_stall", stall, 1);
      check("st_done_early", done, 0);
    end
    tick();
    check("st_c5_done", done, 1);
    check("st_c5_we", mem_we, 0);
    check("st_c5_addr", mem_addr, 0);
    check("st_c5_stall", stall, 0);
    check("st_vload_untouched", vload_data, 0);
    start = 1'b0;
    tick();
    check("st_c6_done", done, 0);

    // vldr base 0xFFFFFFF8: address wrap
    tick();
    start = 1'b1; is_store = 1'b0; base_addr = 32'hFFFFFFF8; vstore_data = 128'h0;
    tick();
    start = 1'b0;
    check("wr_a0", mem_addr, 32'hFFFFFFF8);
    tick(); check("wr_a1", mem_addr, 32'hFFFFFFFC);
    tick(); check("wr_a2", mem_addr, 32'h00000000);
    check("wr_we", mem_we, 0);
    tick(); check("wr_a3", mem_addr, 32'h00000004);
    tick(); check("wr_c5_done", done, 0);
    tick(); check("wr_c6_done", done, 1);

    // vldr base 0x200
    tick();
    start = 1'b1; is_store = 1'b0; base_addr = 32'h200;
    n_writes = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("ld_addr", mem_addr, 32'h200 + 32'(4 * (c - 1)));
      if (mem_we) n_writes++;
    end
    tick();
    check("ld_c5_stall", stall, 1);
    check("ld_c5_done", done, 0);
    check("ld_c5_addr", mem_addr, 0);
    if (mem_we) n_writes++;
    tick();
    check("ld_c6_done", done, 1);
    check("ld_c6_vload", vload_data, ld_exp);
    check("ld_c6_stall", stall, 0);
    if (mem_we) n_writes++;
    check("ld_no_writes", n_writes, 0);
    start = 1'b0;
    tick();
    check("ld_c7_done", done, 0);
    check("ld_c7_vload_hold", vload_data, ld_exp);

    // Two back-to-back vstr with start held high through DONE
    start = 1'b1; is_store = 1'b1; base_addr = 32'h100;
    vstore_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    n_writes = 0; n_done = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_we) n_writes++;
      if (done) n_done++;
      if (c == 6) check("b2b_c6_idle_stall", stall, 1);
      if (c == 6) check("b2b_c6_we", mem_we, 0);
      if (c == 7) check("b2b_c7_addr", mem_addr, 32'h100);
      if (c == 11) begin
        check("b2b_c11_done", done, 1);
        start = 1'b0;
      end
    end
    check("b2b_writes", n_writes, 8);
    check("b2b_dones", n_done, 2);
    check("b2b_vload_hold", vload_data, ld_exp);

    // Reset at cycle 2 of a vstr
    tick();
    start = 1'b1; is_store = 1'b1; base_addr = 32'h100;
    tick();
    tick();
    check("rm_c2_we", mem_we, 1);
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    check("rm_c3_we", mem_we, 0);
    check("rm_c3_vload", vload_data, 0);
    check("rm_c3_stall", stall, 0);
    check("rm_c3_addr", mem_addr, 0);
    n_writes = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_we) n_writes++;
    end
    check("rm_no_writes", n_writes, 0);
    check("rm_done", done, 0);

    // vldr base 0x102: misaligned
    start = 1'b1; is_store = 1'b0; base_addr = 32'h102;
    tick();
    start = 1'b0;
`ifdef VMEM_ALIGN_CHECK_EN
    check("mis_c1_err", err, 1);
    check("mis_c1_done", done, 1);
    check("mis_c1_we", mem_we, 0);
    check("mis_c1_addr", mem_addr, 0);
    tick();
    check("mis_c2_err", err, 0);
    check("mis_c2_done", done, 0);
    check("mis_vload", vload_data, 0);
`else
    check("mis_c1_addr", mem_addr, 32'h100);
    check("mis_c1_err", err, 0);
    check("mis_c1_stall", stall, 1);
    tick(); check("mis_c2_addr", mem_addr, 32'h104);
    tick(); tick(); tick(); tick();
    check("mis_c6_done", done, 1);
    check("mis_c6_err", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vmem_sequencer.md
VMEM_SEQUENCER -- requirements
Module: vmem_sequencer

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 32, meaning memory byte-address width.
REQ-002 The block SHALL expose parameter BEATS, default 4, meaning 32-bit words per 128-bit vector register (fixed at 4; other values unsupported).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  decoded vldr/vstr present in execute stage; level, held while stall=1.
REQ-006 is_store  input  1  1 = vstr (MemWrite path), 0 = vldr (MemToReg=01 path); sampled with start.
REQ-007 base_addr  input  ADDR_W  byte address from rs1; sampled with start.
REQ-008 vstore_data  input  128  vector register contents for vstr; sampled with start.
REQ-009 mem_rdata  input  32  memory read word; valid one cycle after its address.
REQ-010 mem_addr  output  ADDR_W  word-aligned memory byte address.
REQ-011 mem_wdata  output  32  store word.
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 stall  output  1  freeze PC/fetch/decode while high.
REQ-014 vload_data  output  128  assembled vector for VRegWrite.
REQ-015 done  output  1  one-cycle completion pulse; qualifies vector writeback for loads.
REQ-016 err  output  1  one-cycle misalignment pulse (VMEM_ALIGN_CHECK_EN builds only; else tied 0).

Function
REQ-017 FSM states SHALL be IDLE, XFER, LAST, DONE.
REQ-018 IDLE: start=1 -> capture is_store, base_addr (low 2 bits forced 00), vstore_data; beat counter=0; go XFER.
REQ-019 stall SHALL be combinational: 1 in IDLE when start=1, 1 in XFER and LAST, 0 in DONE and in IDLE with start=0.
REQ-020 XFER: mem_addr = base + 4*beat, modulo 2^ADDR_W (wrap past all-ones to 0); beat increments each cycle 0..3.
REQ-021 Word order big-endian: beat 0 <-> bits [127:96], beat 3 <-> bits [31:0].
REQ-022 Store in XFER: mem_we=1, mem_wdata = captured word[beat]; after beat 3 -> DONE.
REQ-023 Load in XFER: mem_we=0; at beats 1..3 capture mem_rdata into word[beat-1]; after beat 3 -> LAST.
REQ-024 LAST (loads only): capture mem_rdata into word 3, mem_we=0 -> DONE.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE next cycle unconditionally.
REQ-026 Latency from start cycle (cycle 0): store done at cycle 5; load done at cycle 6 with vload_data valid.
REQ-027 vload_data SHALL hold its value from DONE until the next load reaches DONE; stores leave it unchanged.
REQ-028 start in XFER, LAST, or DONE SHALL be ignored; a new op is accepted only in IDLE.
REQ-029 Outside XFER: mem_we=0, mem_addr=0, mem_wdata=0.

Reset
REQ-030 rst=1 at any edge SHALL force IDLE, beat=0, vload_data=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset mid-transfer SHALL abandon the op with no further mem_we; stall=0 after reset unless start=1.

Configuration
REQ-032 Macro VMEM_ALIGN_CHECK_EN defined: base_addr[1:0]!=00 with start in IDLE -> go directly to DONE, err=1 and done=1 that cycle, no memory access, vload_data unchanged.
REQ-033 Macro undefined: err tied 0, base_addr[1:0] silently forced to 00, op proceeds normally.

Verification
REQ-034 vstr base=0x100, data=0x00112233_44556677_8899AABB_CCDDEEFF -> cycles 1-4 mem_we=1, addr 0x100/0x104/0x108/0x10C, wdata 0x00112233/0x44556677/0x8899AABB/0xCCDDEEFF; done at cycle 5.
REQ-035 vldr base=0x200, memory words 0xA0A1A2A3,0xB0B1B2B3,0xC0C1C2C3,0xD0D1D2D3 -> done at cycle 6, vload_data=0xA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, mem_we never 1.
REQ-036 vldr base=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-037 rst asserted at cycle 2 of a vstr -> mem_we=0 from cycle 3 on, state IDLE, vload_data=0.
REQ-038 start held high through DONE -> second op begins only at the following IDLE; two back-to-back vstr produce 8 writes and 2 done pulses.
REQ-039 VMEM_ALIGN_CHECK_EN builds: vldr base=0x102 -> err=1 and done=1 at cycle 1, no access; undefined builds: accesses start at 0x100.
